// File: rtl/dcache_pkg.sv
// Shared types and tree-PLRU helpers for the N-way data cache controller.
// The helpers work on a 15-bit tree (enough for 16 ways) and take the
// way-index width as an argument so one body serves every way count.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    RD    = 3'd2,
    FCHK  = 3'd3,
    FWB   = 3'd4,
    FDONE = 3'd5
  } state_t;

  localparam int MAX_WBITS = 4;

  // Walk from the root; each bit points at the subtree holding the victim.
  function automatic logic [MAX_WBITS-1:0] plru_victim(input logic [14:0] plru,
                                                       input int wbits);
    logic [3:0] node;
    logic [3:0] way;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < MAX_WBITS; lvl++) begin
      if (lvl < wbits) begin
        way  = {way[2:0], plru[node]};
        node = {node[2:0], 1'b0} + 4'd1 + {3'b000, plru[node]};
      end
    end
    return way;
  endfunction

  // Point every node on the path to 'way' at the other half of the tree.
  function automatic logic [14:0] plru_update(input logic [14:0] plru,
                                              input logic [MAX_WBITS-1:0] way,
                                              input int wbits);
    logic [3:0]  node;
    logic [3:0]  path;
    logic        b;
    logic [14:0] res;
    res  = plru;
    node = '0;
    path = way << (MAX_WBITS - wbits);
    for (int lvl = 0; lvl < MAX_WBITS; lvl++) begin
      if (lvl < wbits) begin
        b         = path[3];
        res[node] = ~b;
        node      = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
        path      = {path[2:0], 1'b0};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_ctrl_nway_if.sv
// CPU, datapath and cacheline-adaptor signals of the cache controller.
// master = controller side, slave = datapath/CPU/adaptor side.
interface dcache_ctrl_nway_if #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
);
  localparam int WBITS = $clog2(WAYS);

  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  logic                flush_req;
  logic                flush_done;
  logic [WAYS-1:0]     hit_i;
  logic [WAYS-1:0]     valid_i;
  logic [WAYS-1:0]     dirty_i;
  logic [WAYS-2:0]     plru_i;
  logic                plru_load;
  logic [WAYS-2:0]     plru_o;
  logic [WBITS-1:0]    way_sel;
  logic                addr_src;
  logic                set_src;
  logic [SET_BITS-1:0] flush_set;
  logic                din_src;
  logic [WAYS-1:0]     we_mbe;
  logic [WAYS-1:0]     we_all;
  logic [WAYS-1:0]     valid_load;
  logic [WAYS-1:0]     dirty_load;
  logic [WAYS-1:0]     tag_load;
  logic                valid_o;
  logic                dirty_o;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;

  modport master (
    input  mem_read, mem_write, flush_req, hit_i, valid_i, dirty_i, plru_i, pmem_resp,
    output mem_resp, flush_done, plru_load, plru_o, way_sel, addr_src, set_src,
           flush_set, din_src, we_mbe, we_all, valid_load, dirty_load, tag_load,
           valid_o, dirty_o, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, flush_req, hit_i, valid_i, dirty_i, plru_i, pmem_resp,
    input  mem_resp, flush_done, plru_load, plru_o, way_sel, addr_src, set_src,
           flush_set, din_src, we_mbe, we_all, valid_load, dirty_load, tag_load,
           valid_o, dirty_o, pmem_read, pmem_write
  );
endinterface

// File: rtl/dcache_plru.sv
// Victim selection (invalid way first, else tree-PLRU) and the PLRU access
// update for the way that hit. Purely combinational.
module dcache_plru
  import dcache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WBITS = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WBITS-1:0] hit_way,
  output logic [WBITS-1:0] victim,
  output logic [WAYS-2:0]  plru_o
);
  logic [14:0] tree;
  logic [3:0]  hit4;
  logic [3:0]  walk;
  logic [14:0] upd;
  logic        unused_hi;

  // Widen to the helper width, run the walk/update, then pick the victim.
  always_comb begin
    tree              = '0;
    tree[WAYS-2:0]    = plru_i;
    hit4              = '0;
    hit4[WBITS-1:0]   = hit_way;
    walk              = plru_victim(tree, WBITS);
    upd               = plru_update(tree, hit4, WBITS);
    plru_o            = upd[WAYS-2:0];
    victim            = walk[WBITS-1:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim = WBITS'(w);
    end
  end

  assign unused_hi = ^{upd, walk};
endmodule

// File: rtl/dcache_ctrl_nway.sv
// Control FSM for a WAYS-way set-associative write-back, write-allocate
// data cache: hit service, victim writeback/fill, and a full flush walk.
//
//  state | meaning
//  IDLE  | wait for CPU request or flush; hits complete here
//  WB    | write dirty victim line back to memory
//  RD    | read missing line from memory and fill victim way
//  FCHK  | flush: inspect slot fcnt = {set, way}
//  FWB   | flush: write back the dirty slot, then clear its dirty bit
//  FDONE | flush finished, one-cycle flush_done
module dcache_ctrl_nway
  import dcache_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
) (
  input logic               clk,
  input logic               rst,
  dcache_ctrl_nway_if.master bus
);
  localparam int WBITS = $clog2(WAYS);
  localparam int FCW   = SET_BITS + WBITS;

  state_t              state;
  logic [WBITS-1:0]    victim_q;
  logic [WBITS-1:0]    victim;
  logic [WBITS-1:0]    hit_way;
  logic                hit_any;
  logic [WAYS-2:0]     plru_upd;
  logic [FCW-1:0]      fcnt;
  logic [WBITS-1:0]    fway;
  logic [SET_BITS-1:0] fset;
  logic                req;

  assign req  = bus.mem_read | bus.mem_write;
  assign fway = fcnt[WBITS-1:0];
  assign fset = fcnt[FCW-1:WBITS];

  // Encode the hitting way (lowest index wins if several are flagged).
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.hit_i[w]) begin
        hit_any = 1'b1;
        hit_way = WBITS'(w);
      end
    end
  end

  dcache_plru #(.WAYS(WAYS), .WBITS(WBITS)) u_plru (
    .plru_i  (bus.plru_i),
    .valid_i (bus.valid_i),
    .hit_way (hit_way),
    .victim  (victim),
    .plru_o  (plru_upd)
  );

  // State, latched victim and flush counter. CPU requests win over flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
      fcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (!hit_any) begin
              victim_q <= victim;
              state    <= (bus.valid_i[victim] && bus.dirty_i[victim]) ? WB : RD;
            end
          end else if (bus.flush_req) begin
            fcnt  <= '0;
            state <= FCHK;
          end
        end
        WB:  if (bus.pmem_resp) state <= RD;
        RD:  if (bus.pmem_resp) state <= IDLE;
        FCHK: begin
          if (bus.valid_i[fway] && bus.dirty_i[fway]) state <= FWB;
          else if (&fcnt)                             state <= FDONE;
          else                                        fcnt  <= fcnt + FCW'(1);
        end
        FWB: begin
          if (bus.pmem_resp) begin
            if (&fcnt) state <= FDONE;
            else begin
              fcnt  <= fcnt + FCW'(1);
              state <= FCHK;
            end
          end
        end
        FDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state (plus same-cycle hit and pmem_resp qualifiers).
  always_comb begin
    bus.mem_resp   = 1'b0;
    bus.flush_done = 1'b0;
    bus.plru_load  = 1'b0;
    bus.plru_o     = '0;
    bus.way_sel    = '0;
    bus.addr_src   = 1'b0;
    bus.set_src    = 1'b0;
    bus.flush_set  = '0;
    bus.din_src    = 1'b0;
    bus.we_mbe     = '0;
    bus.we_all     = '0;
    bus.valid_load = '0;
    bus.dirty_load = '0;
    bus.tag_load   = '0;
    bus.valid_o    = 1'b0;
    bus.dirty_o    = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    case (state)
      IDLE: begin
        if (req && hit_any) begin
          bus.mem_resp  = 1'b1;
          bus.way_sel   = hit_way;
          bus.plru_load = 1'b1;
          bus.plru_o    = plru_upd;
          if (bus.mem_write) begin
            bus.we_mbe[hit_way]     = 1'b1;
            bus.dirty_load[hit_way] = 1'b1;
            bus.dirty_o             = 1'b1;
          end
        end
      end
      WB: begin
        bus.pmem_write = 1'b1;
        bus.way_sel    = victim_q;
        bus.addr_src   = 1'b1;
      end
      RD: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.din_src              = 1'b1;
          bus.we_all[victim_q]     = 1'b1;
          bus.tag_load[victim_q]   = 1'b1;
          bus.valid_load[victim_q] = 1'b1;
          bus.dirty_load[victim_q] = 1'b1;
          bus.valid_o              = 1'b1;
        end
      end
      FCHK: begin
        bus.set_src   = 1'b1;
        bus.flush_set = fset;
      end
      FWB: begin
        bus.set_src    = 1'b1;
        bus.flush_set  = fset;
        bus.pmem_write = 1'b1;
        bus.way_sel    = fway;
        bus.addr_src   = 1'b1;
        if (bus.pmem_resp) bus.dirty_load[fway] = 1'b1;
      end
      FDONE:   bus.flush_done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed bench for dcache_ctrl_nway (WAYS=4, SET_BITS=3). A behavioural
// array model answers the controller, a memory responder completes line
// transfers, and a monitor compares every meaningful cycle to the model.
module tb_dcache_ctrl_nway;
  logic clk;
  logic rst;

  dcache_ctrl_nway_if #(.WAYS(4), .SET_BITS(3)) bus ();

  dcache_ctrl_nway #(.WAYS(4), .SET_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] tag_a   [8][4];
  logic [3:0] valid_a [8];
  logic [3:0] dirty_a [8];
  logic [2:0] plru_a  [8];
  logic [2:0] cpu_set;
  logic [7:0] cpu_tag;
  logic [2:0] sel;

  int         exp_wb_way, exp_fill_way, exp_hit_way;
  logic [2:0] exp_plru;
  bit         exp_write;
  int         fill_cyc, resp_cyc, fchk_cnt;
  logic [2:0] last_fset;
  logic [4:0] wb_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int w);
    return 4'b0001 << w;
  endfunction

  // Reference PLRU: halve the way range [lo, lo+span) at each node.
  function automatic int m_victim(input logic [3:0] v, input logic [2:0] p);
    int node, lo, span;
    for (int w = 0; w < 4; w++) if (!v[w]) return w;
    node = 0; lo = 0; span = 4;
    while (span > 1) begin
      span = span / 2;
      if (p[node]) begin lo = lo + span; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  function automatic logic [2:0] m_update(input logic [2:0] p, input int w);
    int node, lo, span;
    logic [2:0] r;
    r = p; node = 0; lo = 0; span = 4;
    while (span > 1) begin
      span = span / 2;
      if (w >= lo + span) begin r[node] = 1'b0; lo = lo + span; node = 2 * node + 2; end
      else begin r[node] = 1'b1; node = 2 * node + 1; end
    end
    return r;
  endfunction

  function automatic logic any_out();
    return |{bus.mem_resp, bus.flush_done, bus.plru_load, bus.plru_o, bus.way_sel,
             bus.addr_src, bus.set_src, bus.flush_set, bus.din_src, bus.we_mbe,
             bus.we_all, bus.valid_load, bus.dirty_load, bus.tag_load, bus.valid_o,
             bus.dirty_o, bus.pmem_read, bus.pmem_write};
  endfunction

  // Datapath model: arrays seen through the set mux.
  always_comb begin
    sel         = bus.set_src ? bus.flush_set : cpu_set;
    bus.valid_i = valid_a[sel];
    bus.dirty_i = dirty_a[sel];
    bus.plru_i  = plru_a[sel];
    bus.hit_i   = '0;
    for (int w = 0; w < 4; w++) bus.hit_i[w] = valid_a[sel][w] && (tag_a[sel][w] == cpu_tag);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: 3 cycles of request, then a one-cycle pmem_resp.
  initial begin
    int lat;
    lat = 0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.pmem_resp = 1'b0; lat = 0;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0; lat = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        lat++;
        if (lat == 3) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) wb_log.push_back({sel, bus.way_sel});
        end
      end else lat = 0;
    end
  end

  // Compare process, then commit array writes the controller requested.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.pmem_write && !bus.set_src) begin
        chk("wb_way", 32'(bus.way_sel), 32'(exp_wb_way));
        chk("wb_addr_src", 32'(bus.addr_src), 32'd1);
      end
      if (bus.pmem_write && bus.set_src) begin
        chk("fwb_slot_dirty", 32'(valid_a[bus.flush_set][bus.way_sel] & dirty_a[bus.flush_set][bus.way_sel]), 32'd1);
        chk("fwb_addr_src", 32'(bus.addr_src), 32'd1);
      end
      if (bus.set_src && !bus.pmem_write) begin
        fchk_cnt++;
        last_fset = bus.flush_set;
      end
      if (bus.pmem_read)
        chk("rd_src", 32'({bus.addr_src, bus.set_src, bus.pmem_write}), 32'd0);
      if (|bus.we_all) begin
        fill_cyc = cyc;
        chk("fill_we_all", 32'(bus.we_all), 32'(oh(exp_fill_way)));
        chk("fill_loads", 32'({bus.tag_load, bus.valid_load, bus.dirty_load}),
            32'({oh(exp_fill_way), oh(exp_fill_way), oh(exp_fill_way)}));
        chk("fill_vals", 32'({bus.din_src, bus.valid_o, bus.dirty_o}), 32'b110);
      end
      if (bus.mem_resp) begin
        resp_cyc = cyc;
        chk("hit_way", 32'(bus.way_sel), 32'(exp_hit_way));
        chk("hit_plru", 32'({bus.plru_load, bus.plru_o}), 32'({1'b1, exp_plru}));
        chk("hit_we_mbe", 32'(bus.we_mbe), exp_write ? 32'(oh(exp_hit_way)) : 32'd0);
        chk("hit_dirty", 32'({bus.dirty_load, bus.dirty_o}),
            exp_write ? 32'({oh(exp_hit_way), 1'b1}) : 32'd0);
      end
      for (int w = 0; w < 4; w++) begin
        if (bus.tag_load[w])   tag_a[sel][w]   = cpu_tag;
        if (bus.valid_load[w]) valid_a[sel][w] = bus.valid_o;
        if (bus.dirty_load[w]) dirty_a[sel][w] = bus.dirty_o;
      end
      if (bus.plru_load) plru_a[sel] = bus.plru_o;
    end
  end

  task automatic wait_resp(output int n, output bit ok);
    n = 0; ok = 1'b0;
    repeat (100) begin
      @(negedge clk); #3;
      if (bus.mem_resp) begin
        ok = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        return;
      end
      n++;
    end
  endtask

  task automatic wait_flush(output bit ok);
    ok = 1'b0;
    repeat (400) begin
      @(negedge clk); #3;
      if (bus.flush_done) begin
        ok = 1'b1;
        bus.flush_req = 1'b0;
        return;
      end
    end
  endtask

  task automatic issue(input bit wr, input logic [2:0] s, input logic [7:0] t);
    @(posedge clk); #1;
    cpu_set = s; cpu_tag = t;
    bus.mem_read = !wr; bus.mem_write = wr;
  endtask

  initial begin
    int n;
    bit ok;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit ok;
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.flush_req = 1'b0;
    cpu_set = '0; cpu_tag = '0;
    exp_wb_way = 0; exp_fill_way = 0; exp_hit_way = 0; exp_plru = '0; exp_write = 1'b0;
    fill_cyc = 0; resp_cyc = 0; fchk_cnt = 0; last_fset = '0;
    for (int s = 0; s < 8; s++) begin
      valid_a[s] = '0; dirty_a[s] = '0; plru_a[s] = '0;
      for (int w = 0; w < 4; w++) tag_a[s][w] = '0;
    end

    // Model pins: hand-computed PLRU results.
    chk("model_upd_way2", 32'(m_update(3'b000, 2)), 32'b100);
    chk("model_upd_way0", 32'(m_update(3'b000, 0)), 32'b011);
    chk("model_vic_plru", 32'(m_victim(4'b1111, 3'b011)), 32'd2);
    chk("model_vic_invalid", 32'(m_victim(4'b1011, 3'b000)), 32'd2);

    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("reset_outputs", 32'(any_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: cold read miss fills way0; mem_resp one cycle after the fill.
    exp_fill_way = 0; exp_hit_way = 0; exp_plru = 3'b011; exp_write = 1'b0;
    issue(1'b0, 3'd2, 8'd5);
    wait_resp(n, ok);
    chk("t1_resp_seen", 32'(ok), 32'd1);
    chk("t1_resp_after_fill", 32'(resp_cyc - fill_cyc), 32'd1);
    chk("t1_line", 32'({valid_a[2], tag_a[2][0]}), 32'({4'b0001, 8'd5}));
    chk("t1_no_wb", 32'(wb_log.size()), 32'd0);

    // 2: store hit way2 with tree 000, responds in the issue cycle.
    valid_a[3] = 4'hf; dirty_a[3] = 4'h0; plru_a[3] = 3'b000;
    for (int w = 0; w < 4; w++) tag_a[3][w] = 8'(10 + w);
    exp_hit_way = 2; exp_plru = 3'b100; exp_write = 1'b1;
    issue(1'b1, 3'd3, 8'd12);
    wait_resp(n, ok);
    chk("t2_same_cycle", 32'(n), 32'd0);
    chk("t2_arrays", 32'({dirty_a[3], 1'b0, plru_a[3]}), 32'({4'b0100, 1'b0, 3'b100}));

    // 3: full set, tree points at dirty way2: writeback, then fill way2.
    valid_a[4] = 4'hf; dirty_a[4] = 4'b0100; plru_a[4] = 3'b011;
    for (int w = 0; w < 4; w++) tag_a[4][w] = 8'(20 + w);
    exp_wb_way = 2; exp_fill_way = 2; exp_hit_way = 2;
    exp_plru = m_update(3'b011, 2); exp_write = 1'b0;
    chk("t3_model_plru", 32'(exp_plru), 32'b110);
    issue(1'b0, 3'd4, 8'd30);
    wait_resp(n, ok);
    chk("t3_resp_seen", 32'(ok), 32'd1);
    chk("t3_wb_count", 32'(wb_log.size()), 32'd1);
    if (wb_log.size() > 0) chk("t3_wb_slot", 32'(wb_log[0]), 32'({3'd4, 2'd2}));
    chk("t3_line", 32'({dirty_a[4], tag_a[4][2]}), 32'({4'b0000, 8'd30}));
    wb_log.delete();

    // 4: flush with dirty slots {1,3} and {7,0}.
    for (int s = 0; s < 8; s++) dirty_a[s] = '0;
    valid_a[1] = 4'b1000; dirty_a[1] = 4'b1000;
    valid_a[7] = 4'b0001; dirty_a[7] = 4'b0001;
    fchk_cnt = 0;
    @(posedge clk); #1;
    bus.flush_req = 1'b1;
    wait_flush(ok);
    chk("t4_done", 32'(ok), 32'd1);
    chk("t4_wb_count", 32'(wb_log.size()), 32'd2);
    if (wb_log.size() == 2) begin
      chk("t4_wb0", 32'(wb_log[0]), 32'({3'd1, 2'd3}));
      chk("t4_wb1", 32'(wb_log[1]), 32'({3'd7, 2'd0}));
    end
    chk("t4_slots_walked", 32'(fchk_cnt), 32'd32);
    chk("t4_last_set", 32'(last_fset), 32'd7);
    chk("t4_after", 32'({valid_a[1], dirty_a[1], valid_a[7], dirty_a[7]}), 32'h8010);
    wb_log.delete();

    // 5: read hit and flush_req together: read first, flush afterwards.
    valid_a[5] = 4'b0010; tag_a[5][1] = 8'd40; plru_a[5] = 3'b000;
    exp_hit_way = 1; exp_plru = m_update(3'b000, 1); exp_write = 1'b0;
    fchk_cnt = 0;
    @(posedge clk); #1;
    cpu_set = 3'd5; cpu_tag = 8'd40;
    bus.mem_read = 1'b1; bus.flush_req = 1'b1;
    wait_resp(n, ok);
    chk("t5_resp_first", 32'({ok, 8'(n), 8'(fchk_cnt)}), 32'({1'b1, 8'd0, 8'd0}));
    wait_flush(ok);
    chk("t5_flush_done", 32'(ok), 32'd1);
    chk("t5_flush_walk", 32'({8'(fchk_cnt), 8'(wb_log.size())}), 32'({8'd32, 8'd0}));

    // 6: reset during a writeback drops pmem_write without a clock edge.
    valid_a[6] = 4'hf; dirty_a[6] = 4'b0001; plru_a[6] = 3'b000;
    for (int w = 0; w < 4; w++) tag_a[6][w] = 8'(60 + w);
    exp_wb_way = 0; exp_fill_way = 0;
    issue(1'b0, 3'd6, 8'd70);
    ok = 1'b0;
    repeat (20) begin
      @(negedge clk); #3;
      if (bus.pmem_write) begin ok = 1'b1; break; end
    end
    chk("t6_wb_started", 32'(ok), 32'd1);
    rst = 1'b1;
    bus.mem_read = 1'b0;
    #1;
    chk("t6_async_drop", 32'({bus.pmem_write, any_out()}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #3;
    chk("t6_idle_after", 32'(any_out()), 32'd0);
    chk("t6_arrays", 32'({valid_a[6], dirty_a[6], tag_a[6][0]}), 32'({4'hf, 4'b0001, 8'd60}));
    chk("t6_no_wb", 32'(wb_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
